// File: rtl/mpadder_arbiter.sv
`default_nettype none
// mpadder_arbiter: two-requester arbiter sharing one multi-precision adder/subtractor.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break (default build: fixed priority, requester 0 wins).
module mpadder_arbiter #(
    parameter int WIDTH     = 1031,
    parameter int ADDER_LAT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0,
    input  logic             req1,
    input  logic             sub0,
    input  logic             sub1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    output logic             add_subtract,
    input  logic [WIDTH-1:0] add_result
);

    localparam logic [3:0] LAT_C = 4'(ADDER_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             owner_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             sub_q;
    logic [WIDTH-1:0] result_q;
    logic             done0_q;
    logic             done1_q;
    logic             busy_q;

    logic             pick1;
    logic             grant;

    // owner_q doubles as "last served"; it resets to 1 so requester 0 wins the first tie.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick1 = req1 && (!req0 || !owner_q);
`else
        pick1 = req1 && !req0;
`endif
    end

    assign grant = resetn && (state_q == S_IDLE) && (req0 || req1);
    assign gnt0  = grant && !pick1;
    assign gnt1  = grant && pick1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b1;
            opa_q    <= '0;
            opb_q    <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        opa_q   <= pick1 ? a1 : a0;
                        opb_q   <= pick1 ? b1 : b0;
                        sub_q   <= pick1 ? sub1 : sub0;
                        owner_q <= pick1;
                        cnt_q   <= LAT_C;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        result_q <= add_result;
                        done0_q  <= !owner_q;
                        done1_q  <= owner_q;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done0        = done0_q;
    assign done1        = done1_q;
    assign result       = result_q;
    assign busy         = busy_q;
    assign add_in_a     = opa_q;
    assign add_in_b     = opb_q;
    assign add_subtract = sub_q;

endmodule

`default_nettype wire

// File: tb/tb_mpadder_arbiter.sv
`default_nettype none
// tb_mpadder_arbiter: runs an ADDER_LAT=1 and an ADDER_LAT=3 arbiter on shared stimulus,
// each against a cycle-level behavioural model, plus hand-computed literal expectations.
module tb_mpadder_arbiter;

    localparam int W  = 1031;
    localparam int NI = 2;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    logic [NI-1:0] gnt0_w, gnt1_w, done0_w, done1_w, busy_w, sub_w;
    logic [W-1:0]  res_w  [NI];
    logic [W-1:0]  ain_w  [NI];
    logic [W-1:0]  bin_w  [NI];
    logic [W-1:0]  addr_w [NI];

    always #5 clk = ~clk;

    // Shared-adder stand-in: combinational, operands are held stable for the whole BUSY phase.
    for (genvar g = 0; g < NI; g++) begin : g_adder
        assign addr_w[g] = sub_w[g] ? (ain_w[g] - bin_w[g]) : (ain_w[g] + bin_w[g]);
    end

    mpadder_arbiter #(.WIDTH(W), .ADDER_LAT(1)) u_dut_l1 (
        .clk(clk), .resetn(resetn), .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .done0(done0_w[0]), .done1(done1_w[0]),
        .result(res_w[0]), .busy(busy_w[0]), .add_in_a(ain_w[0]), .add_in_b(bin_w[0]),
        .add_subtract(sub_w[0]), .add_result(addr_w[0])
    );

    mpadder_arbiter #(.WIDTH(W), .ADDER_LAT(3)) u_dut_l3 (
        .clk(clk), .resetn(resetn), .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .done0(done0_w[1]), .done1(done1_w[1]),
        .result(res_w[1]), .busy(busy_w[1]), .add_in_a(ain_w[1]), .add_in_b(bin_w[1]),
        .add_subtract(sub_w[1]), .add_result(addr_w[1])
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s t=%0t: got low64=%h top8=%h, expected low64=%h top8=%h",
                      nm, $time, act[63:0], act[W-1:W-8], exp[63:0], exp[W-1:W-8]);
    endtask

    // ---------------- behavioural model (per instance) ----------------
    longint       cyc = 0;
    longint       free_at [NI];
    longint       done_at [NI];
    logic         owner   [NI];
    logic         last    [NI];
    logic [W-1:0] m_a     [NI];
    logic [W-1:0] m_b     [NI];
    logic         m_sub   [NI];
    logic [W-1:0] m_pend  [NI];
    logic [W-1:0] m_res   [NI];

    logic m_idle, m_win, m_g0, m_g1, m_d0, m_d1;

    initial begin
        for (int k = 0; k < NI; k++) begin
            free_at[k] = 0; done_at[k] = -1; owner[k] = 1'b1; last[k] = 1'b1;
            m_a[k] = '0; m_b[k] = '0; m_sub[k] = 1'b0; m_pend[k] = '0; m_res[k] = '0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!resetn) begin
                free_at[k] = 0; done_at[k] = -1; owner[k] = 1'b1; last[k] = 1'b1;
                m_a[k] = '0; m_b[k] = '0; m_sub[k] = 1'b0; m_res[k] = '0;
                chk($sformatf("rst_gnt0[%0d]", k), W'(gnt0_w[k]), '0);
                chk($sformatf("rst_gnt1[%0d]", k), W'(gnt1_w[k]), '0);
                chk($sformatf("rst_done[%0d]", k), W'({done0_w[k], done1_w[k]}), '0);
                chk($sformatf("rst_busy[%0d]", k), W'(busy_w[k]), '0);
                chk($sformatf("rst_result[%0d]", k), res_w[k], '0);
                chk($sformatf("rst_add_in_a[%0d]", k), ain_w[k], '0);
                chk($sformatf("rst_add_in_b[%0d]", k), bin_w[k], '0);
                chk($sformatf("rst_add_sub[%0d]", k), W'(sub_w[k]), '0);
            end else begin
                m_idle = (cyc >= free_at[k]);
                m_g0 = 1'b0; m_g1 = 1'b0; m_win = 1'b0;
                if (m_idle && (req0 || req1)) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (req0 && req1) m_win = ~last[k];
                    else              m_win = req1;
`else
                    m_win = req1 && !req0;
`endif
                    m_g0 = !m_win; m_g1 = m_win;
                end
                m_d0 = (cyc == done_at[k]) && (owner[k] == 1'b0);
                m_d1 = (cyc == done_at[k]) && (owner[k] == 1'b1);
                if (cyc == done_at[k]) m_res[k] = m_pend[k];

                chk($sformatf("gnt0[lat%0d]", lat_of(k)), W'(gnt0_w[k]), W'(m_g0));
                chk($sformatf("gnt1[lat%0d]", lat_of(k)), W'(gnt1_w[k]), W'(m_g1));
                chk($sformatf("done0[lat%0d]", lat_of(k)), W'(done0_w[k]), W'(m_d0));
                chk($sformatf("done1[lat%0d]", lat_of(k)), W'(done1_w[k]), W'(m_d1));
                chk($sformatf("busy[lat%0d]", lat_of(k)), W'(busy_w[k]), W'(!m_idle));
                chk($sformatf("result[lat%0d]", lat_of(k)), res_w[k], m_res[k]);
                chk($sformatf("add_in_a[lat%0d]", lat_of(k)), ain_w[k], m_a[k]);
                chk($sformatf("add_in_b[lat%0d]", lat_of(k)), bin_w[k], m_b[k]);
                chk($sformatf("add_sub[lat%0d]", lat_of(k)), W'(sub_w[k]), W'(m_sub[k]));

                if (m_g0 || m_g1) begin
                    m_a[k]   = m_win ? a1 : a0;
                    m_b[k]   = m_win ? b1 : b0;
                    m_sub[k] = m_win ? sub1 : sub0;
                    m_pend[k] = m_sub[k] ? (m_a[k] - m_b[k]) : (m_a[k] + m_b[k]);
                    owner[k] = m_win;
                    last[k]  = m_win;
                    done_at[k] = cyc + lat_of(k) + 1;
                    free_at[k] = cyc + lat_of(k) + 2;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    logic [15:0] h_g0, h_g1, h_d0, h_d1, h_b3;

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Records instance-0 grant/done and instance-1 busy, bit i = i-th cycle from now.
    task automatic watch(input int n, input bit drop);
        h_g0 = '0; h_g1 = '0; h_d0 = '0; h_d1 = '0; h_b3 = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h_g0[i] = gnt0_w[0]; h_g1[i] = gnt1_w[0];
            h_d0[i] = done0_w[0]; h_d1[i] = done1_w[0];
            h_b3[i] = busy_w[1];
            @(posedge clk); #1;
            if (drop && i == 0) begin req0 = 1'b0; req1 = 1'b0; end
        end
    endtask

    typedef struct {
        logic         r0, r1, s0, s1, pulse;
        logic [W-1:0] va0, vb0, va1, vb1;
    } vec_t;

    vec_t vecs [6];
    logic [W-1:0] ones;
    logic [W-1:0] all_but_0;

    initial begin
        ones = '1;
        all_but_0 = ones - W'(1);
        vecs[0] = '{r0:1, r1:0, s0:0, s1:0, pulse:0, va0:ones, vb0:W'(1), va1:'0, vb1:'0};
        vecs[1] = '{r0:0, r1:1, s0:0, s1:1, pulse:0, va0:'0, vb0:'0, va1:'0, vb1:W'(1)};
        vecs[2] = '{r0:1, r1:1, s0:1, s1:0, pulse:1, va0:W'(100), vb0:W'(58), va1:W'(9), vb1:W'(9)};
        vecs[3] = '{r0:1, r1:1, s0:0, s1:1, pulse:0, va0:W'(64'hDEAD_BEEF_0000_0001), vb0:ones,
                    va1:{1'b1, {(W-1){1'b0}}}, vb1:W'(2)};
        vecs[4] = '{r0:0, r1:1, s0:1, s1:0, pulse:1, va0:W'(3), vb0:W'(4),
                    va1:{1'b1, {(W-1){1'b0}}}, vb1:{1'b1, {(W-1){1'b0}}}};
        vecs[5] = '{r0:1, r1:0, s0:1, s1:1, pulse:0, va0:W'(12345), vb0:W'(12345), va1:'0, vb1:'0};

        repeat (3) step();
        resetn = 1'b1;
        step();

        // Single add from requester 0.
        req0 = 1'b1; a0 = W'(5); b0 = W'(3); sub0 = 1'b0;
        watch(8, 1'b1);
        chk("s1_gnt0_cycles", W'(h_g0), W'(16'h0001));
        chk("s1_done0_cycles", W'(h_d0), W'(16'h0004));
        chk("s1_done1_never", W'(h_d1), '0);
        chk("s1_result_l1", res_w[0], W'(8));
        chk("s1_busy_l3", W'(h_b3), W'(16'h001E));
        chk("s1_result_l3", res_w[1], W'(8));

        // Subtraction wrap from requester 1: 3 - 5.
        req1 = 1'b1; a1 = W'(3); b1 = W'(5); sub1 = 1'b1;
        watch(8, 1'b1);
        chk("s2_gnt1_cycles", W'(h_g1), W'(16'h0001));
        chk("s2_done1_cycles", W'(h_d1), W'(16'h0004));
        chk("s2_result_wrap_l1", res_w[0], {{(W-1){1'b1}}, 1'b0});
        chk("s2_result_wrap_l3", res_w[1], {{(W-1){1'b1}}, 1'b0});

        // Both requests held from reset: back-to-back arbitration.
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1; req0 = 1'b1; req1 = 1'b1;
        watch(9, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
        chk("s3_tie_gnt0", W'(h_g0), W'(16'h0041));
        chk("s3_tie_gnt1", W'(h_g1), W'(16'h0008));
`else
        chk("s3_tie_gnt0", W'(h_g0), W'(16'h0049));
        chk("s3_tie_gnt1", W'(h_g1), '0);
`endif
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) step();

        // Reset pulse during BUSY aborts the operation.
        req0 = 1'b1; a0 = W'(7); b0 = W'(9); sub0 = 1'b0;
        step();
        req0 = 1'b0; req1 = 1'b1; a1 = W'(11); b1 = W'(4); sub1 = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        chk("s4_busy_in_reset", W'(busy_w[0]), '0);
        chk("s4_result_in_reset", res_w[0], '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        watch(6, 1'b1);
        chk("s4_held_req_gnt1", W'(h_g1), W'(16'h0001));
        chk("s4_no_done0", W'(h_d0), '0);
        chk("s4_done1_cycles", W'(h_d1), W'(16'h0004));
        chk("s4_result", res_w[0], W'(7));
        repeat (4) step();

        // Directed vectors; operands scrambled after the grant edge.
        for (int v = 0; v < 6; v++) begin
            req0 = vecs[v].r0; req1 = vecs[v].r1; sub0 = vecs[v].s0; sub1 = vecs[v].s1;
            a0 = vecs[v].va0; b0 = vecs[v].vb0; a1 = vecs[v].va1; b1 = vecs[v].vb1;
            step();
            req0 = 1'b0; req1 = 1'b0;
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            sub0 = ~sub0; sub1 = ~sub1;
            if (vecs[v].pulse) begin
                req1 = 1'b1;
                step();
                req1 = 1'b0;
            end
            repeat (7) step();
        end

        repeat (4) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mpadder_arbiter.md
MPADDER_ARBITER -- requirements
Module: mpadder_arbiter

Interface
REQ-001 Parameter WIDTH, default 1031: operand and result width in bits.
REQ-002 Parameter ADDER_LAT, default 1, legal range 1..15: cycles from stable adder inputs to a valid add_result.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  level request from requester 0 / 1.
REQ-006 sub0, sub1  input  1 each  operation select: 0 = a+b, 1 = a-b.
REQ-007 a0, b0, a1, b1  input  WIDTH each  operands of requester 0 / 1.
REQ-008 gnt0, gnt1  output  1 each  grant; operands are latched at the edge ending the grant cycle.
REQ-009 done0, done1  output  1 each  single-cycle pulse: result valid for that requester.
REQ-010 result  output  WIDTH  registered result of the last completed operation.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 add_in_a, add_in_b  output  WIDTH each  operands to the shared mpadder.
REQ-013 add_subtract  output  1  subtract select to the shared mpadder.
REQ-014 add_result  input  WIDTH  result from the shared mpadder.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE: if either req is high, assert the selected gnt combinationally in the same cycle; at the next edge, latch that requester's a, b and sub into the operand registers, record the owner, load the counter with ADDER_LAT, and go to BUSY.
REQ-017 IDLE with no req: remain in IDLE; gnt0 = gnt1 = 0.
REQ-018 At most one gnt is high in any cycle; gnt is never high outside IDLE.
REQ-019 BUSY: the counter decrements each cycle; at the edge where the counter reaches 1, capture add_result into result and go to DONE. BUSY therefore lasts exactly ADDER_LAT cycles.
REQ-020 DONE: assert done<owner> for exactly one cycle, then return to IDLE. Minimum of one IDLE cycle between operations.
REQ-021 Latency: done occurs ADDER_LAT+1 cycles after the gnt cycle; back-to-back throughput is one operation per ADDER_LAT+2 cycles.
REQ-022 add_in_a, add_in_b and add_subtract are driven only from the operand registers and hold their values in every state until the next grant.
REQ-023 result holds its value until the next DONE capture.
REQ-024 Arithmetic: the result is the adder's WIDTH-bit output unmodified; a subtraction with a < b yields the two's-complement wrap modulo 2^WIDTH.
REQ-025 Requests arriving during BUSY or DONE are neither latched nor lost; a held req is arbitrated at the next IDLE.
REQ-026 A req dropped before its gnt causes no operation. A req still high in the cycle after done is treated as a new request.
REQ-027 Operand inputs of the granted requester are sampled only at the grant edge; later changes do not affect the operation in flight.

Reset
REQ-028 resetn low immediately forces: state IDLE, counter 0, operand registers 0, result 0, owner/last-served = requester 1, and all of gnt, done and busy = 0.
REQ-029 Reset asserted during BUSY or DONE aborts the operation; no done pulse is emitted for it.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: when both requests are high, grant the requester not served last. After reset, requester 0 wins the first tie.
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins a tie. A continuously held req0 may starve req1.

Verification
REQ-032 Reset: during and after reset, all outputs are 0 and busy = 0.
REQ-033 ADDER_LAT=1; req0 with a0=5, b0=3, sub0=0 -> gnt0 in cycle 0, done0 in cycle 2, result=8, done1 never asserted.
REQ-034 req1 with a1=3, b1=5, sub1=1 -> done1 with result = 2^1031 - 2 (all ones except bit 0).
REQ-035 req0 and req1 held high from reset -> with the macro: gnt0 at cycle 0, gnt1 at cycle 3, gnt0 at cycle 6 (alternating); without the macro: gnt0 at cycles 0, 3, 6 and gnt1 never.
REQ-036 resetn pulsed low during BUSY -> busy = 0 immediately, no done pulse, result = 0; after release, a held req is granted on the first cycle.
REQ-037 ADDER_LAT=3; a single request -> busy high for 4 cycles, done 4 cycles after gnt, adder inputs stable throughout.
